player_grid_move: RTL and testbench

// - Parametrised successor of the per-clock player mover: frame-rate motion at a

---
 rtl/bomber_pkg.sv | 24 ++
 rtl/grid_assist.sv | 31 +++
 rtl/player_grid_move.sv | 161 ++++++++++++++++
 tb/tb_player_grid_move.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bomber_pkg.sv
// Shared types for the Bomberman movers: directions, collision edge codes, mover FSM states.
package bomber_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_LEFT   = 1;
  localparam int EDGE_RIGHT  = 2;
  localparam int EDGE_TOP    = 3;
  localparam int EDGE_CORNER = 4;

  typedef enum logic [2:0] {IDLE_ST, MOVE_ST, SOF_ST, CHANGE_ST, LIMITS_ST} state_t;

  // One-hot mask of the obstacle edge that faces a given travel direction.
  function automatic logic [4:0] edge_mask(dir_t d);
    case (d)
      DIR_UP:   edge_mask = 5'b1 << EDGE_TOP;
      DIR_DOWN: edge_mask = 5'b1 << EDGE_BOTTOM;
      DIR_LEFT: edge_mask = 5'b1 << EDGE_LEFT;
      default:  edge_mask = 5'b1 << EDGE_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/grid_assist.sv
// Cross-axis tile alignment nudge: returns a signed pixel correction that moves px
// toward the nearest grid line, limited to SPEED_PX per frame.
module grid_assist #(
  parameter int TILE     = 32,
  parameter int SPEED_PX = 2,
  localparam int TB      = $clog2(TILE)
) (
  input  logic [TB-1:0]      px,
  input  logic [TB-1:0]      grid0,
  output logic signed [31:0] corr
);

  localparam logic [TB-1:0] HALF = TB'(TILE / 2);
  localparam logic [TB-1:0] SPD  = TB'(SPEED_PX);

  logic [TB-1:0] off, rem, mag_lo, mag_hi;

  // Only the in-tile phase matters, so modular arithmetic on the low bits suffices.
  always_comb begin
    off    = px - grid0;
    rem    = -off;
    mag_lo = (off < SPD) ? off : SPD;
    mag_hi = (rem < SPD) ? rem : SPD;
    corr   = '0;
    if (off != '0) begin
      if (off < HALF) corr = -$signed(32'(mag_lo));
      else            corr =  $signed(32'(mag_hi));
    end
  end

endmodule

// File: rtl/player_grid_move.sv
// Frame-rate player mover on the tile grid: fixed-point step, collision push-back,
// corner assist and playfield clamping; outputs feed the player bitmap top-left.
module player_grid_move
  import bomber_pkg::*;
#(
  parameter int INITIAL_X = 272,
  parameter int INITIAL_Y = 176,
  parameter int OBJECT_W  = 32,
  parameter int OBJECT_H  = 32,
  parameter int FRAC_BITS = 12,
  parameter int SPEED_PX  = 2,
  parameter int TILE      = 32,
  parameter int GRID_X0   = 16,
  parameter int GRID_Y0   = 48,
  parameter int FRAME_R   = 624,
  parameter int FRAME_B   = 464
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        up_direction_key,
  input  logic        down_direction_key,
  input  logic        left_direction_key,
  input  logic        right_direction_key,
  input  logic        collision,
  input  logic [2:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        moving,
  output logic [1:0]  dir
);

  localparam int TB     = $clog2(TILE);
  localparam int STEP   = SPEED_PX << FRAC_BITS;
  localparam int INIT_X = INITIAL_X << FRAC_BITS;
  localparam int INIT_Y = INITIAL_Y << FRAC_BITS;
  localparam int X_MIN  = GRID_X0 << FRAC_BITS;
  localparam int Y_MIN  = GRID_Y0 << FRAC_BITS;
  localparam int X_MAX  = (FRAME_R - OBJECT_W) << FRAC_BITS;
  localparam int Y_MAX  = (FRAME_B - OBJECT_H) << FRAC_BITS;

  state_t             state_q, state_d;
  logic signed [31:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic signed [31:0] prevx_q, prevx_d, prevy_q, prevy_d;
  logic [4:0]         hit_q, hit_d;
  logic [3:0]         key_acc_q, key_acc_d;
  logic               moving_q, moving_d;
  logic               blocked_q, blocked_d;
  dir_t               dir_q, dir_d;

  logic [3:0]         keys;
  logic signed [31:0] corr_x, corr_y;
  dir_t               picked;

  assign keys     = {right_direction_key, left_direction_key, down_direction_key, up_direction_key};
  assign topLeftX = 11'(xpos_q >>> FRAC_BITS);
  assign topLeftY = 11'(ypos_q >>> FRAC_BITS);
  assign moving   = moving_q;
  assign dir      = dir_q;

  grid_assist #(.TILE(TILE), .SPEED_PX(SPEED_PX)) u_assist_x (
    .px(TB'(xpos_q >>> FRAC_BITS)), .grid0(TB'(GRID_X0)), .corr(corr_x));
  grid_assist #(.TILE(TILE), .SPEED_PX(SPEED_PX)) u_assist_y (
    .px(TB'(ypos_q >>> FRAC_BITS)), .grid0(TB'(GRID_Y0)), .corr(corr_y));

  always_comb begin
    if      (key_acc_q[0]) picked = DIR_UP;
    else if (key_acc_q[1]) picked = DIR_DOWN;
    else if (key_acc_q[2]) picked = DIR_LEFT;
    else                   picked = DIR_RIGHT;
  end

  always_comb begin
    state_d   = state_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    prevx_d   = prevx_q;
    prevy_d   = prevy_q;
    hit_d     = hit_q;
    key_acc_d = key_acc_q;
    moving_d  = moving_q;
    blocked_d = blocked_q;
    dir_d     = dir_q;
    case (state_q)
      IDLE_ST: begin
        xpos_d = INIT_X;
        ypos_d = INIT_Y;
        if (startOfFrame) state_d = MOVE_ST;
      end
      MOVE_ST: begin
        key_acc_d = key_acc_q | keys;
        if (collision)
          for (int i = 0; i < 5; i++)
            if (HitEdgeCode == 3'(i)) hit_d[i] = 1'b1;
        if (startOfFrame) state_d = SOF_ST;
      end
      SOF_ST: begin
        blocked_d = moving_q & (hit_q[EDGE_CORNER] | (|(hit_q & edge_mask(dir_q))));
        if (blocked_d) begin
          xpos_d = prevx_q;
          ypos_d = prevy_q;
        end
        hit_d   = '0;
        state_d = CHANGE_ST;
      end
      CHANGE_ST: begin
        prevx_d  = xpos_q;
        prevy_d  = ypos_q;
        moving_d = 1'b0;
        // Pushing on into the same wall that just blocked us is not a step.
        if ((|key_acc_q) && !(picked == dir_q && blocked_q)) begin
          moving_d = 1'b1;
          dir_d    = picked;
          case (picked)
            DIR_UP:   begin ypos_d = ypos_q - STEP; xpos_d = xpos_q + (corr_x <<< FRAC_BITS); end
            DIR_DOWN: begin ypos_d = ypos_q + STEP; xpos_d = xpos_q + (corr_x <<< FRAC_BITS); end
            DIR_LEFT: begin xpos_d = xpos_q - STEP; ypos_d = ypos_q + (corr_y <<< FRAC_BITS); end
            default:  begin xpos_d = xpos_q + STEP; ypos_d = ypos_q + (corr_y <<< FRAC_BITS); end
          endcase
        end
        key_acc_d = '0;
        state_d   = LIMITS_ST;
      end
      LIMITS_ST: begin
        if      (xpos_q < X_MIN) xpos_d = X_MIN;
        else if (xpos_q > X_MAX) xpos_d = X_MAX;
        if      (ypos_q < Y_MIN) ypos_d = Y_MIN;
        else if (ypos_q > Y_MAX) ypos_d = Y_MAX;
        state_d = MOVE_ST;
      end
      default: state_d = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE_ST;
      xpos_q    <= INIT_X;
      ypos_q    <= INIT_Y;
      prevx_q   <= INIT_X;
      prevy_q   <= INIT_Y;
      hit_q     <= '0;
      key_acc_q <= '0;
      moving_q  <= 1'b0;
      blocked_q <= 1'b0;
      dir_q     <= DIR_UP;
    end else begin
      state_q   <= state_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      prevx_q   <= prevx_d;
      prevy_q   <= prevy_d;
      hit_q     <= hit_d;
      key_acc_q <= key_acc_d;
      moving_q  <= moving_d;
      blocked_q <= blocked_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_player_grid_move.sv
// Scoreboard bench for player_grid_move: each frame pushes its expected position,
// a monitor samples the outputs 3 clocks after every startOfFrame and compares.
module tb_player_grid_move;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sof = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        collision = 1'b0;
  logic [2:0]  code = 3'd0;
  logic [10:0] tlx, tly;
  logic        moving;
  logic [1:0]  dir;

  typedef struct {int x; int y; int m; int d;} exp_t;
  exp_t q[$];
  int passed = 0;
  int total  = 0;

  localparam logic [3:0] K_U = 4'b0001, K_D = 4'b0010, K_R = 4'b1000, K_0 = 4'b0000;

  player_grid_move dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .up_direction_key(up), .down_direction_key(down),
    .left_direction_key(left), .right_direction_key(right),
    .collision(collision), .HitEdgeCode(code),
    .topLeftX(tlx), .topLeftY(tly), .moving(moving), .dir(dir));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int em, input int ed);
    chk({tag, ".x"}, int'(tlx), ex);
    chk({tag, ".y"}, int'(tly), ey);
    chk({tag, ".moving"}, int'(moving), em);
    chk({tag, ".dir"}, int'(dir), ed);
  endtask

  // Monitor: a new position is presented 3 clocks after each startOfFrame.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sof && resetN) begin
        repeat (3) @(posedge clk);
        #1;
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_frame: output at %0t with no expectation queued", $time);
        end else begin
          e = q.pop_front();
          chk_all("frame", e.x, e.y, e.m, e.d);
        end
      end
    end
  end

  // coll < 0: no collision; at_sof puts the hit in the same clock as startOfFrame.
  task automatic frame(input logic [3:0] k, input int coll, input bit at_sof,
                       input int ex, input int ey, input int em, input int ed);
    @(negedge clk);
    {right, left, down, up} = k;
    repeat (4) @(negedge clk);
    if (coll >= 0 && !at_sof) begin
      collision = 1'b1; code = 3'(coll);
      @(negedge clk);
      collision = 1'b0;
    end
    repeat (2) @(negedge clk);
    sof = 1'b1;
    if (coll >= 0 && at_sof) begin collision = 1'b1; code = 3'(coll); end
    q.push_back('{ex, ey, em, ed});
    @(negedge clk);
    sof = 1'b0; collision = 1'b0;
    {right, left, down, up} = K_0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int x, y;
    repeat (3) @(negedge clk);
    chk_all("reset", 272, 176, 0, 0);
    resetN = 1'b1;

    frame(K_0, -1, 0, 272, 176, 0, 0);       // first SOF leaves IDLE
    frame(K_R, -1, 0, 274, 176, 1, 3);
    frame(K_D, -1, 0, 272, 178, 1, 1);       // X off=2 -> nudged left
    frame(K_D, -1, 0, 272, 180, 1, 1);
    frame(K_R, -1, 0, 274, 178, 1, 3);       // Y off=4 -> -2
    for (y = 180; y <= 200; y += 2) frame(K_D, -1, 0, 272, y, 1, 1);
    frame(K_R, -1, 0, 274, 202, 1, 3);       // Y off=24 -> +2
    frame(K_R,  2, 0, 272, 200, 0, 3);       // blocked: restore, no step
    frame(K_R, -1, 0, 274, 202, 1, 3);
    frame(K_R,  2, 1, 272, 200, 0, 3);       // hit in the SOF clock counts
    frame(K_R, -1, 0, 274, 202, 1, 3);
    frame(K_R,  6, 0, 276, 204, 1, 3);       // invalid edge code ignored; off=26 -> +2
    frame(K_U | K_R, -1, 0, 274, 202, 1, 0); // up wins; X off=4 -> -2
    frame(K_U | K_D, -1, 0, 272, 200, 1, 0);
    for (y = 198; y >= 48; y -= 2) frame(K_U, -1, 0, 272, y, 1, 0);
    frame(K_U, -1, 0, 272, 48, 1, 0);
    frame(K_U, -1, 0, 272, 48, 1, 0);
    for (x = 274; x <= 592; x += 2) frame(K_R, -1, 0, x, 48, 1, 3);
    for (int i = 0; i < 3; i++) frame(K_R, -1, 0, 592, 48, 1, 3);
    frame(K_0, -1, 0, 592, 48, 0, 3);        // no key: stop, dir held

    @(negedge clk);
    right = 1'b1;
    repeat (3) @(negedge clk);
    resetN = 1'b0;
    #1;
    chk_all("midreset", 272, 176, 0, 0);
    @(negedge clk);
    resetN = 1'b1;
    right = 1'b0;
    @(negedge clk);
    chk_all("after_reset", 272, 176, 0, 0);
    frame(K_R, -1, 0, 272, 176, 0, 0);       // keys ignored in IDLE
    frame(K_R, -1, 0, 274, 176, 1, 3);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expected frames never observed, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
